// File: rtl/jk_drive_pkg.sv
// +----------------------------------------------------------------------+
// | jk_drive_pkg: shared state encoding and counter sizing for the       |
// |               JK drive encoder.                                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package jk_drive_pkg;

    localparam int C_STATE_W = 2;
    // Four bits covers the full legal TIMEOUT range of 1..15.
    localparam int C_CNT_W   = 4;

    typedef enum logic [C_STATE_W-1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/jk_excite.sv
// +----------------------------------------------------------------------+
// | jk_excite: combinational J/K excitation for a vector of JK flops.    |
// | Build option: JK_DRIVE_TOGGLE_EN selects toggle (j=k=1) encoding.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module jk_excite
    import jk_drive_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_target,
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k
);

    logic [WIDTH-1:0] w_diff;

    assign w_diff = (i_q ^ i_target) & i_mask;

`ifdef JK_DRIVE_TOGGLE_EN
    assign o_j = w_diff;
    assign o_k = w_diff;
`else
    // Set bits that must rise, reset bits that must fall; never both.
    assign o_j = w_diff & ~i_q;
    assign o_k = w_diff &  i_q;
`endif

endmodule

`default_nettype wire

// File: rtl/jk_drive_encoder.sv
// +----------------------------------------------------------------------+
// | jk_drive_encoder: accepts a target Q word, drives J/K for one cycle, |
// |   then waits for the JK bank to match or times out.                  |
// | Build option: JK_DRIVE_TOGGLE_EN (see jk_excite).                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module jk_drive_encoder
    import jk_drive_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_target,
    input  logic [WIDTH-1:0] in_mask,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LIMIT = C_CNT_W'(TIMEOUT);

    state_t             r_state;
    logic [WIDTH-1:0]   r_target;
    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_j;
    logic [WIDTH-1:0]   r_k;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_done;
    logic               r_err;

    logic [WIDTH-1:0]   w_j;
    logic [WIDTH-1:0]   w_k;
    logic [WIDTH-1:0]   w_mismatch;

    // Excitation is computed straight from the request so J/K land one edge after the handshake.
    jk_excite #(
        .WIDTH (WIDTH)
    ) u_excite (
        .i_q      (q_fb),
        .i_target (in_target),
        .i_mask   (in_mask),
        .o_j      (w_j),
        .o_k      (w_k)
    );

    assign w_mismatch = (q_fb ^ r_target) & r_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_mask   <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_target <= in_target;
                        r_mask   <= in_mask;
                        r_j      <= w_j;
                        r_k      <= w_k;
                        r_state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_cnt   <= '0;
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (w_mismatch == '0) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_cnt == C_CNT_LIMIT) begin
                        // TIMEOUT mismatching edges have already been counted.
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                default: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == IDLE) && reset;
    assign busy     = (r_state != IDLE);
    assign j        = r_j;
    assign k        = r_k;
    assign done     = r_done;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_jk_drive_encoder.sv
// +----------------------------------------------------------------------+
// | tb_jk_drive_encoder: directed self-checking bench with a behavioural |
// |   JK bank model closing the feedback loop.                           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_jk_drive_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_target;
    logic [3:0] in_mask;
    logic [3:0] q_fb;
    logic [3:0] j;
    logic [3:0] k;
    logic       busy;
    logic       done;
    logic       err;

    logic       ld;
    logic [3:0] ld_val;
    logic       stuck;
    logic [3:0] r_q = 4'b0000;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jk_drive_encoder #(
        .WIDTH   (4),
        .TIMEOUT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_target (in_target),
        .in_mask   (in_mask),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Behavioural JK bank: preload, freeze, or follow the J/K excitation.
    always @(posedge clk) begin
        if (ld) begin
            r_q <= ld_val;
        end else if (!stuck) begin
            for (int i = 0; i < 4; i++) begin
                case ({j[i], k[i]})
                    2'b10:   r_q[i] <= 1'b1;
                    2'b01:   r_q[i] <= 1'b0;
                    2'b11:   r_q[i] <= ~r_q[i];
                    default: r_q[i] <= r_q[i];
                endcase
            end
        end
    end

    assign q_fb = r_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic load_q(input logic [3:0] v);
        ld     = 1'b1;
        ld_val = v;
        tick();
        ld     = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_j2;
`ifdef JK_DRIVE_TOGGLE_EN
        exp_j2 = 4'b0011;
`else
        exp_j2 = 4'b0000;
`endif
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_target = 4'b0000;
        in_mask   = 4'b0000;
        ld        = 1'b0;
        ld_val    = 4'b0000;
        stuck     = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_j", j, 4'b0000);
        chk("rst_k", k, 4'b0000);
        chk("rst_busy", {3'b0, busy}, 4'd0);
        chk("rst_done", {3'b0, done}, 4'd0);
        chk("rst_err", {3'b0, err}, 4'd0);
        reset = 1'b1;
        #1;
        chk("rst_ready", {3'b0, in_ready}, 4'd1);

        // Set from 0000 to 1010, full mask
        load_q(4'b0000);
        in_valid = 1'b1; in_target = 4'b1010; in_mask = 4'b1111;
        tick();
        in_valid = 1'b0;
        chk("t1_j", j, 4'b1010);
        chk("t1_k", k, 4'b0000);
        chk("t1_busy", {3'b0, busy}, 4'd1);
        chk("t1_ready", {3'b0, in_ready}, 4'd0);
        tick();
        chk("t1_j_clr", j, 4'b0000);
        chk("t1_done_early", {3'b0, done}, 4'd0);
        chk("t1_q", q_fb, 4'b1010);
        tick();
        chk("t1_done", {3'b0, done}, 4'd1);
        chk("t1_err", {3'b0, err}, 4'd0);
        chk("t1_ready2", {3'b0, in_ready}, 4'd1);
        chk("t1_busy2", {3'b0, busy}, 4'd0);
        tick();
        chk("t1_done_pulse", {3'b0, done}, 4'd0);

        // Clear low two bits from 1111
        load_q(4'b1111);
        in_valid = 1'b1; in_target = 4'b0000; in_mask = 4'b0011;
        tick();
        in_valid = 1'b0;
        chk("t2_j", j, exp_j2);
        chk("t2_k", k, 4'b0011);
        tick();
        tick();
        chk("t2_done", {3'b0, done}, 4'd1);
        chk("t2_q", q_fb, 4'b1100);

        // Stuck bank: timeout
        load_q(4'b0000);
        stuck = 1'b1;
        in_valid = 1'b1; in_target = 4'b0001; in_mask = 4'b1111;
        tick();
        in_valid = 1'b0;
        chk("t3_j", j, 4'b0001);
        tick();
        tick();
        chk("t3_c1_err", {3'b0, err}, 4'd0);
        chk("t3_c1_done", {3'b0, done}, 4'd0);
        chk("t3_c1_busy", {3'b0, busy}, 4'd1);
        tick();
        chk("t3_c2_err", {3'b0, err}, 4'd0);
        tick();
        chk("t3_c3_err", {3'b0, err}, 4'd0);
        chk("t3_c3_busy", {3'b0, busy}, 4'd1);
        tick();
        chk("t3_err", {3'b0, err}, 4'd1);
        chk("t3_no_done", {3'b0, done}, 4'd0);
        chk("t3_ready", {3'b0, in_ready}, 4'd1);
        tick();
        chk("t3_err_pulse", {3'b0, err}, 4'd0);
        stuck = 1'b0;

        // Back-to-back requests with in_valid held
        load_q(4'b0000);
        in_valid = 1'b1; in_target = 4'b0001; in_mask = 4'b1111;
        tick();
        in_target = 4'b0011;
        tick();
        tick();
        chk("t4_done1", {3'b0, done}, 4'd1);
        chk("t4_q1", q_fb, 4'b0001);
        chk("t4_ready", {3'b0, in_ready}, 4'd1);
        tick();
        in_valid = 1'b0;
        chk("t4_acc2_j", j, 4'b0010);
        chk("t4_acc2_done", {3'b0, done}, 4'd0);
        chk("t4_acc2_busy", {3'b0, busy}, 4'd1);
        tick();
        chk("t4_gap_done", {3'b0, done}, 4'd0);
        tick();
        chk("t4_done2", {3'b0, done}, 4'd1);
        chk("t4_q2", q_fb, 4'b0011);

        // Empty mask completes on first CHECK edge
        in_valid = 1'b1; in_target = 4'b1111; in_mask = 4'b0000;
        tick();
        in_valid = 1'b0;
        chk("t5_j", j, 4'b0000);
        chk("t5_k", k, 4'b0000);
        chk("t5_busy", {3'b0, busy}, 4'd1);
        tick();
        chk("t5_j2", j, 4'b0000);
        tick();
        chk("t5_done", {3'b0, done}, 4'd1);
        chk("t5_q", q_fb, 4'b0011);

        // Reset asserted mid-DRIVE
        load_q(4'b0000);
        in_valid = 1'b1; in_target = 4'b0101; in_mask = 4'b1111;
        tick();
        in_valid = 1'b0;
        chk("t6_j", j, 4'b0101);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_j", j, 4'b0000);
        chk("t6_rst_k", k, 4'b0000);
        chk("t6_rst_busy", {3'b0, busy}, 4'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("t6_ready", {3'b0, in_ready}, 4'd1);
        chk("t6_q", q_fb, 4'b0000);
        tick();
        chk("t6_no_done", {3'b0, done}, 4'd0);
        chk("t6_no_err", {3'b0, err}, 4'd0);
        chk("t6_busy", {3'b0, busy}, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
